out_port_fifo: RTL and testbench

//   Output-port end of the CPU's I/O path: captures BusMuxOut when the control sequence asserts

---
 rtl/cpu_pkg.sv | 11 +
 rtl/out_port_fifo_if.sv | 27 ++
 rtl/out_port_fifo_sync_fifo.sv | 70 +++++++
 rtl/out_port_fifo.sv | 55 +++++
 tb/tb_out_port_fifo.sv | 121 ++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the occupancy encoding used by the output-port FIFO.
package cpu_pkg;
    localparam int WORD_W         = 32;
    localparam int OUT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;
endpackage

// File: rtl/out_port_fifo_if.sv
// CPU-to-device bundle for the output port: write strobe and bus word in, handshake and status out.
interface out_port_fifo_if import cpu_pkg::*; #(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = OUT_FIFO_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
);
    logic             OutPortin;
    logic [WIDTH-1:0] BusMuxOut;
    logic             port_full;
    logic             port_empty;
    logic [CNT_W-1:0] port_count;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;
    logic [WIDTH-1:0] last_value;

    modport slave (
        input  OutPortin, BusMuxOut, out_ready,
        output port_full, port_empty, port_count, out_data, out_valid, overflow, last_value
    );

    modport master (
        output OutPortin, BusMuxOut, out_ready,
        input  port_full, port_empty, port_count, out_data, out_valid, overflow, last_value
    );
endinterface

// File: rtl/out_port_fifo_sync_fifo.sv
// Circular-buffer FIFO; full/empty come from the registered occupancy state, not pointer compare.
module sync_fifo import cpu_pkg::*; #(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = OUT_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    occ_state_e       state_r;

    // Next occupancy; callers guarantee no push when full without pop and no pop when empty.
    always_comb begin
        count_next_s = count_r;
        if (push && !pop) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (pop && !push) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, count and occupancy state.
    always_ff @(posedge clock) begin
        if (!clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            state_r  <= OCC_EMPTY;
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r <= count_next_s;
            case (state_r)
                OCC_EMPTY:   state_r <= push ? OCC_PARTIAL : OCC_EMPTY;
                OCC_PARTIAL: begin
                    if (count_next_s == CNT_W'(DEPTH))          state_r <= OCC_FULL;
                    else if (count_next_s == {CNT_W{1'b0}})     state_r <= OCC_EMPTY;
                    else                                        state_r <= OCC_PARTIAL;
                end
                OCC_FULL:    state_r <= (pop && !push) ? OCC_PARTIAL : OCC_FULL;
                default:     state_r <= OCC_EMPTY;
            endcase
        end
    end

    // Storage is never cleared: stale words are unreachable while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) mem_r[wr_ptr_r] <= wdata;
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (state_r == OCC_FULL);
    assign empty = (state_r == OCC_EMPTY);
endmodule

// File: rtl/out_port_fifo.sv
// CPU output port: qualifies out-instruction writes into a small FIFO toward the device,
// flags dropped writes and keeps the last accepted word for the display.
module out_port_fifo import cpu_pkg::*; #(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = OUT_FIFO_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          clear,
    out_port_fifo_if.slave bus
);
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [CNT_W-1:0] count_s;
    logic [WIDTH-1:0] rdata_s;
    logic             overflow_r;
    logic [WIDTH-1:0] last_value_r;

    // A write into a full FIFO still lands when the head drains in the same cycle.
    assign pop_s  = !empty_s && bus.out_ready;
    assign push_s = bus.OutPortin && (!full_s || pop_s);

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (bus.BusMuxOut),
        .rdata (rdata_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Sticky drop flag and display register.
    always_ff @(posedge clock) begin
        if (!clear) begin
            overflow_r   <= 1'b0;
            last_value_r <= {WIDTH{1'b0}};
        end else begin
            if (bus.OutPortin && !push_s) overflow_r <= 1'b1;
            if (push_s) last_value_r <= bus.BusMuxOut;
        end
    end

    assign bus.port_full  = full_s;
    assign bus.port_empty = empty_s;
    assign bus.port_count = count_s;
    assign bus.out_data   = rdata_s;
    assign bus.out_valid  = !empty_s;
    assign bus.overflow   = overflow_r;
    assign bus.last_value = last_value_r;
endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo: directed scenarios plus random traffic against a queue model.
module tb_out_port_fifo;
    import cpu_pkg::*;

    logic clock;
    logic clear;
    int   checks;
    int   errors;

    logic [WORD_W-1:0] model_q[$];
    logic              model_ovf;
    logic [WORD_W-1:0] model_last;

    out_port_fifo_if bus ();

    out_port_fifo dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = model_q.size();
        check("count",      32'(bus.port_count), 32'(n));
        check("valid",      32'(bus.out_valid),  32'(n != 0));
        check("empty",      32'(bus.port_empty), 32'(n == 0));
        check("full",       32'(bus.port_full),  32'(n == OUT_FIFO_DEPTH));
        check("overflow",   32'(bus.overflow),   32'(model_ovf));
        check("last_value", bus.last_value,      model_last);
        if (n != 0) check("out_data", bus.out_data, model_q[0]);
    endtask

    // One clock: apply inputs, advance the model by the same rules, then compare after the edge.
    task automatic step(input logic wr, input logic [WORD_W-1:0] d, input logic rdy, input logic clr);
        logic do_pop;
        logic do_push;
        bus.OutPortin = wr;
        bus.BusMuxOut = d;
        bus.out_ready = rdy;
        clear         = clr;
        if (!clr) begin
            model_q.delete();
            model_ovf  = 1'b0;
            model_last = '0;
        end else begin
            do_pop  = (model_q.size() > 0) && rdy;
            do_push = wr && ((model_q.size() < OUT_FIFO_DEPTH) || do_pop);
            if (wr && !do_push) model_ovf = 1'b1;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                model_q.push_back(d);
                model_last = d;
            end
        end
        @(posedge clock);
        #1;
        check_all();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_ovf  = 1'b0;
        model_last = '0;
        bus.OutPortin = 1'b1;
        bus.BusMuxOut = 32'hDEAD_BEEF;
        bus.out_ready = 1'b0;
        clear = 1'b0;

        // Reset held two cycles with a write strobe active
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Single word, then one-cycle drain
        step(1'b1, 32'h0000_00A5, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Fill, overflow, drain
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b1);
        step(1'b1, 32'd5, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b1);
        step(1'b1, 32'd9, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Streaming through the pointers
        for (int i = 0; i < 10; i++) step(1'b1, 32'h10 + 32'(i), 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);

        // Reset in the middle of a backlog
        for (int i = 0; i < 3; i++) step(1'b1, 32'h40 + 32'(i), 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 2) != 0), $urandom(),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
